// File: rtl/ctrl_fsm_if.sv
// Control-path bundle between ctrl_fsm and the datapath/memory side of the core.
// Handshake: a request (imem_req/dmem_req) stays high until its ready is seen high on a rising edge; ready is ignored while no request is up.
interface ctrl_fsm_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic [15:0]      instr;
    logic             imem_ready;
    logic             dmem_ready;
    logic             zero;
    logic             imem_req;
    logic             irwrite;
    logic             pcen;
    logic             memtoreg;
    logic             pcsrc;
    logic             alusrc;
    logic             regdst;
    logic             regwrite;
    logic             jump;
    logic [2:0]       alucontrol;
    logic             dmem_req;
    logic             memwrite;
    logic             halted;
    logic             error;
    logic [CNT_W-1:0] retired;

    modport master (
        input  run, instr, imem_ready, dmem_ready, zero,
        output imem_req, irwrite, pcen, memtoreg, pcsrc, alusrc, regdst,
               regwrite, jump, alucontrol, dmem_req, memwrite, halted, error,
               retired
    );

    modport slave (
        output run, instr, imem_ready, dmem_ready, zero,
        input  imem_req, irwrite, pcen, memtoreg, pcsrc, alusrc, regdst,
               regwrite, jump, alucontrol, dmem_req, memwrite, halted, error,
               retired
    );
endinterface

// File: rtl/ctrl_fsm.sv
// Multicycle control FSM: fetch/decode/exec/mem/writeback sequencing for 16-bit instructions.
// o_dbg_state encoding: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 HALT, 6 ERR.
module ctrl_fsm #(
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           reset,
    ctrl_fsm_if.master     bus,
    output logic [2:0]     o_dbg_state
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_LW   = 4'b0001;
    localparam logic [3:0] OP_SW   = 4'b0010;
    localparam logic [3:0] OP_BEQ  = 4'b0011;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_J    = 4'b0101;
    localparam logic [3:0] OP_HALT = 4'b1111;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_opcode;
    logic [2:0]       r_funct;
    logic [CNT_W-1:0] r_retired;

    logic       w_latch;
    logic       w_retire;
    logic       w_legal;
    logic [2:0] w_alu;
    logic       w_imem_req;
    logic       w_irwrite;
    logic       w_pcen;
    logic       w_memtoreg;
    logic       w_pcsrc;
    logic       w_alusrc;
    logic       w_regdst;
    logic       w_regwrite;
    logic       w_jump;
    logic [2:0] w_alucontrol;
    logic       w_dmem_req;
    logic       w_memwrite;
    logic       w_halted;
    logic       w_error;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_opcode  <= '0;
            r_funct   <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_opcode <= bus.instr[15:12];
                r_funct  <= bus.instr[2:0];
            end
            if (w_retire) r_retired <= r_retired + CNT_ONE;
        end
    end

    // Legality and ALU code come only from the fields latched at fetch.
    always_comb begin
        w_legal = 1'b1;
        w_alu   = 3'b000;
        case (r_opcode)
            OP_R: begin
                case (r_funct)
                    3'b000:  w_alu = 3'b010;
                    3'b001:  w_alu = 3'b110;
                    3'b010:  w_alu = 3'b000;
                    3'b011:  w_alu = 3'b001;
                    3'b100:  w_alu = 3'b111;
                    default: w_legal = 1'b0;
                endcase
            end
            OP_LW, OP_SW, OP_ADDI: w_alu = 3'b010;
            OP_BEQ:                w_alu = 3'b110;
            OP_J, OP_HALT:         w_alu = 3'b000;
            default:               w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_next       = r_state;
        w_latch      = 1'b0;
        w_retire     = 1'b0;
        w_imem_req   = 1'b0;
        w_irwrite    = 1'b0;
        w_pcen       = 1'b0;
        w_memtoreg   = 1'b0;
        w_pcsrc      = 1'b0;
        w_alusrc     = 1'b0;
        w_regdst     = 1'b0;
        w_regwrite   = 1'b0;
        w_jump       = 1'b0;
        w_alucontrol = 3'b000;
        w_dmem_req   = 1'b0;
        w_memwrite   = 1'b0;
        w_halted     = 1'b0;
        w_error      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_imem_req = bus.run;
                if (bus.run && bus.imem_ready) begin
                    w_irwrite = 1'b1;
                    w_latch   = 1'b1;
                    w_next    = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!w_legal)                 w_next = S_ERR;
                else if (r_opcode == OP_HALT) w_next = S_HALT;
                else                          w_next = S_EXEC;
            end
            S_EXEC: begin
                w_alucontrol = w_alu;
                case (r_opcode)
                    OP_R: begin
                        w_regdst = 1'b1;
                        w_next   = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        w_alusrc = 1'b1;
                        w_next   = S_MEM;
                    end
                    OP_ADDI: begin
                        w_alusrc = 1'b1;
                        w_next   = S_WB;
                    end
                    OP_BEQ: begin
                        w_pcsrc  = bus.zero;
                        w_pcen   = 1'b1;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                    OP_J: begin
                        w_jump   = 1'b1;
                        w_pcen   = 1'b1;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                    default: w_next = S_ERR;
                endcase
            end
            S_MEM: begin
                w_alucontrol = w_alu;
                w_alusrc     = 1'b1;
                w_dmem_req   = 1'b1;
                w_memwrite   = (r_opcode == OP_SW);
                if (bus.dmem_ready) begin
                    if (r_opcode == OP_SW) begin
                        w_pcen   = 1'b1;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end
            end
            S_WB: begin
                w_regwrite = 1'b1;
                w_memtoreg = (r_opcode == OP_LW);
                w_regdst   = (r_opcode == OP_R);
                w_pcen     = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_HALT:  w_halted = 1'b1;
            S_ERR:   w_error  = 1'b1;
            default: w_next   = S_FETCH;
        endcase
    end

    assign bus.imem_req   = w_imem_req;
    assign bus.irwrite    = w_irwrite;
    assign bus.pcen       = w_pcen;
    assign bus.memtoreg   = w_memtoreg;
    assign bus.pcsrc      = w_pcsrc;
    assign bus.alusrc     = w_alusrc;
    assign bus.regdst     = w_regdst;
    assign bus.regwrite   = w_regwrite;
    assign bus.jump       = w_jump;
    assign bus.alucontrol = w_alucontrol;
    assign bus.dmem_req   = w_dmem_req;
    assign bus.memwrite   = w_memwrite;
    assign bus.halted     = w_halted;
    assign bus.error      = w_error;
    assign bus.retired    = r_retired;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed bench for ctrl_fsm: a 16-bit-counter instance and a 4-bit-counter instance share stimulus.
module tb_ctrl_fsm;
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    // Packed output vector layout: {imem_req, irwrite, pcen, memtoreg, pcsrc, alusrc,
    // regdst, regwrite, jump, alucontrol[2:0], dmem_req, memwrite, halted, error}
    localparam logic [15:0] O_IMEM   = 16'h8000;
    localparam logic [15:0] O_IRW    = 16'h4000;
    localparam logic [15:0] O_PCEN   = 16'h2000;
    localparam logic [15:0] O_M2R    = 16'h1000;
    localparam logic [15:0] O_PCSRC  = 16'h0800;
    localparam logic [15:0] O_ALUSRC = 16'h0400;
    localparam logic [15:0] O_REGDST = 16'h0200;
    localparam logic [15:0] O_REGW   = 16'h0100;
    localparam logic [15:0] O_JUMP   = 16'h0080;
    localparam logic [15:0] ALU_ADD  = 16'h0020;
    localparam logic [15:0] ALU_SUB  = 16'h0060;
    localparam logic [15:0] O_DMEM   = 16'h0008;
    localparam logic [15:0] O_MEMW   = 16'h0004;
    localparam logic [15:0] O_HALT   = 16'h0002;
    localparam logic [15:0] O_ERR    = 16'h0001;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] instr;
    logic        imem_ready;
    logic        dmem_ready;
    logic        zero;
    logic [2:0]  dbg;
    logic [2:0]  dbg4;
    logic [15:0] obs;
    int          total = 0;
    int          bad = 0;
    logic [2:0]  exp_q[$];

    always #5 clk = ~clk;

    ctrl_fsm_if #(.CNT_W(16)) bus ();
    ctrl_fsm_if #(.CNT_W(4))  bus4 ();

    assign bus.run         = run;
    assign bus.instr       = instr;
    assign bus.imem_ready  = imem_ready;
    assign bus.dmem_ready  = dmem_ready;
    assign bus.zero        = zero;
    assign bus4.run        = run;
    assign bus4.instr      = instr;
    assign bus4.imem_ready = imem_ready;
    assign bus4.dmem_ready = dmem_ready;
    assign bus4.zero       = zero;

    ctrl_fsm #(.CNT_W(16)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg)
    );

    ctrl_fsm #(.CNT_W(4)) u_dut4 (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus4),
        .o_dbg_state (dbg4)
    );

    assign obs = {bus.imem_req, bus.irwrite, bus.pcen, bus.memtoreg, bus.pcsrc,
                  bus.alusrc, bus.regdst, bus.regwrite, bus.jump, bus.alucontrol,
                  bus.dmem_req, bus.memwrite, bus.halted, bus.error};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: inputs were set after the previous rising edge; check at the falling edge.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [15:0] exp);
        @(negedge clk);
        #1;
        check({tag, "_st"}, 32'(dbg), 32'(st));
        check({tag, "_out"}, 32'(obs), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [15:0] w, input string tag);
        run        = 1'b1;
        instr      = w;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        cyc({tag, "_f"}, S_FETCH, O_IMEM | O_IRW);
        imem_ready = 1'b0;
        instr      = 16'($urandom_range(0, 65535));
        cyc({tag, "_d"}, S_DECODE, 16'h0000);
    endtask

    task automatic pulse_reset(input string tag);
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check({tag, "_rst_st"}, 32'(dbg), 32'(S_FETCH));
        check({tag, "_rst_out"}, 32'(obs), 32'(O_IMEM));
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic bad_instr(input logic [15:0] w, input string tag);
        fetch(w, tag);
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        for (int k = 0; k < 3; k++) cyc({tag, "_err"}, S_ERR, O_ERR);
        pulse_reset(tag);
    endtask

    initial begin
        reset      = 1'b0;
        run        = 1'b0;
        instr      = 16'h0000;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        zero       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(dbg), 32'(S_FETCH));
        check("rst_out", 32'(obs), 32'h0);
        check("rst_retired", 32'(bus.retired), 32'h0);
        reset = 1'b1;

        // run low: fetch not taken even with imem_ready high
        imem_ready = 1'b1;
        instr      = 16'h0001;
        cyc("idle0", S_FETCH, 16'h0000);
        cyc("idle1", S_FETCH, 16'h0000);

        // R-type sub
        fetch(16'h0001, "sub");
        cyc("sub_x", S_EXEC, O_REGDST | ALU_SUB);
        cyc("sub_w", S_WB, O_REGW | O_PCEN | O_REGDST);
        check("sub_ret", 32'(bus.retired), 32'd1);
        cyc("sub_nx", S_FETCH, O_IMEM);

        // lw with three wait cycles; stray imem_ready must be ignored
        fetch(16'h1abc, "lw");
        cyc("lw_x", S_EXEC, O_ALUSRC | ALU_ADD);
        imem_ready = 1'b1;
        for (int k = 0; k < 3; k++) cyc("lw_mw", S_MEM, O_ALUSRC | O_DMEM | ALU_ADD);
        dmem_ready = 1'b1;
        cyc("lw_m", S_MEM, O_ALUSRC | O_DMEM | ALU_ADD);
        dmem_ready = 1'b0;
        imem_ready = 1'b0;
        cyc("lw_w", S_WB, O_REGW | O_M2R | O_PCEN);
        check("lw_ret", 32'(bus.retired), 32'd2);

        // beq taken then not taken
        zero = 1'b1;
        fetch(16'h3000, "beq1");
        cyc("beq1_x", S_EXEC, O_PCEN | O_PCSRC | ALU_SUB);
        zero = 1'b0;
        fetch(16'h3000, "beq0");
        cyc("beq0_x", S_EXEC, O_PCEN | ALU_SUB);
        check("beq_ret", 32'(bus.retired), 32'd4);

        // sw zero-wait, addi, j
        fetch(16'h2000, "sw");
        cyc("sw_x", S_EXEC, O_ALUSRC | ALU_ADD);
        dmem_ready = 1'b1;
        cyc("sw_m", S_MEM, O_ALUSRC | O_DMEM | O_MEMW | O_PCEN | ALU_ADD);
        fetch(16'h4000, "addi");
        cyc("addi_x", S_EXEC, O_ALUSRC | ALU_ADD);
        cyc("addi_w", S_WB, O_REGW | O_PCEN);
        fetch(16'h5000, "j");
        cyc("j_x", S_EXEC, O_JUMP | O_PCEN);
        check("mix_ret", 32'(bus.retired), 32'd7);

        // R-type funct table
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b110);
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b111);
        for (int f = 0; f < 5; f++) begin
            logic [2:0] e;
            e = exp_q.pop_front();
            fetch({13'h0, 3'(f)}, "alu");
            cyc("alu_x", S_EXEC, O_REGDST | {9'h0, e, 4'h0});
            cyc("alu_w", S_WB, O_REGW | O_PCEN | O_REGDST);
        end
        check("alu_ret", 32'(bus.retired), 32'd12);

        // reset mid-MEM of a stalled sw
        fetch(16'h2000, "swr");
        cyc("swr_x", S_EXEC, O_ALUSRC | ALU_ADD);
        dmem_ready = 1'b0;
        cyc("swr_m", S_MEM, O_ALUSRC | O_DMEM | O_MEMW | ALU_ADD);
        pulse_reset("swr");
        check("swr_ret", 32'(bus.retired), 32'd0);

        // illegal opcode, illegal funct
        bad_instr(16'h7000, "ill_op");
        bad_instr(16'h0006, "ill_fn");

        // 4-bit counter wrap on the narrow instance
        for (int i = 1; i <= 17; i++) begin
            fetch(16'h5000, "jw");
            cyc("jw_x", S_EXEC, O_JUMP | O_PCEN);
            if (i == 15) check("wrap15", 32'(bus4.retired), 32'd15);
            if (i == 16) check("wrap16", 32'(bus4.retired), 32'd0);
        end
        check("wrap17", 32'(bus4.retired), 32'd1);
        check("wide17", 32'(bus.retired), 32'd17);
        fetch(16'hf000, "halt");
        imem_ready = 1'b1;
        for (int k = 0; k < 3; k++) cyc("halt_h", S_HALT, O_HALT);
        check("halt4_st", 32'(dbg4), 32'(S_HALT));
        check("halt4_imem", 32'(bus4.imem_req), 32'd0);
        check("halt4_flag", 32'(bus4.halted), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
